// File: rtl/sqrt_arbiter_pkg.sv
// Shared types and sizing helpers for the square-root arbiter and its
// round-robin selector.
package sqrt_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } sqrt_arb_state_t;

    function automatic int sqrt_arb_id_bits(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    localparam int SQRT_ARB_NUM_REQ_DEF = 4;
    localparam int SQRT_ARB_ID_BITS     = sqrt_arb_id_bits(SQRT_ARB_NUM_REQ_DEF);

endpackage

// File: rtl/IntSqrt.sv
// Iterative integer square-root engine: one result bit pair per enabled cycle,
// done held high from completion until the next trigger is accepted.
module IntSqrt #(
    parameter int NUM_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                trigger,
    input  logic [NUM_BITS-1:0] num_in,
    output logic                rdy,
    output logic                done,
    output logic [NUM_BITS-1:0] sqrt_out
);

    localparam int HALF = (NUM_BITS + 1) / 2;
    localparam int W    = 2 * HALF;

    logic [W-1:0] x_q, x_d;
    logic [W-1:0] res_q, res_d;
    logic [W-1:0] bit_q, bit_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [W-1:0] trial;

    always_comb begin
        x_d    = x_q;
        res_d  = res_q;
        bit_d  = bit_q;
        busy_d = busy_q;
        done_d = done_q;
        trial  = res_q + bit_q;
        if (busy_q) begin
            // Digit recurrence: res carries the partial root shifted left by the remaining bit position.
            if (x_q >= trial) begin
                x_d   = x_q - trial;
                res_d = (res_q >> 1) + bit_q;
            end else begin
                res_d = res_q >> 1;
            end
            bit_d = bit_q >> 2;
            if (bit_q == W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (trigger) begin
            x_d    = W'(num_in);
            res_d  = '0;
            bit_d  = W'(1) << (W - 2);
            busy_d = 1'b1;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            res_q  <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (en) begin
            x_q    <= x_d;
            res_q  <= res_d;
            bit_q  <= bit_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign rdy      = ~busy_q;
    assign done     = done_q;
    assign sqrt_out = res_q[NUM_BITS-1:0];

endmodule

// File: rtl/sqrt_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// scanning upward and wrapping at NUM_REQ.
module rr_pick
    import sqrt_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = sqrt_arb_id_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_BITS-1:0] ptr,
    output logic [ID_BITS-1:0] idx,
    output logic               found
);

    int unsigned cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                idx   = ID_BITS'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one IntSqrt engine among NUM_REQ requesters;
// one request in flight, result held until the winner acknowledges.
module sqrt_arbiter
    import sqrt_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BITS = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*NUM_BITS-1:0]   req_num,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [NUM_BITS-1:0]           resp_sqrt,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    input  logic [NUM_REQ-1:0]            resp_ack,
    output logic                          busy
);

    localparam int ID_BITS = sqrt_arb_id_bits(NUM_REQ);

    sqrt_arb_state_t     state_q, state_d;
    logic [ID_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_BITS-1:0]  id_q, id_d;
    logic [NUM_BITS-1:0] op_q, op_d;
    logic [NUM_BITS-1:0] res_q, res_d;

    logic [ID_BITS-1:0]  pick_idx;
    logic                pick_found;
    logic [NUM_BITS-1:0] op_sel;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [NUM_REQ-1:0]  id_onehot;
    logic                ack_hit;

    logic                eng_trigger;
    logic                eng_rdy;
    logic                eng_done;
    logic [NUM_BITS-1:0] eng_sqrt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    IntSqrt #(
        .NUM_BITS (NUM_BITS)
    ) u_int_sqrt (
        .clk      (clk),
        .reset    (~reset),
        .en       (clk_en),
        .trigger  (eng_trigger),
        .num_in   (op_q),
        .rdy      (eng_rdy),
        .done     (eng_done),
        .sqrt_out (eng_sqrt)
    );

    // Constant-index decode of the winner and the served id avoids variable part-selects.
    always_comb begin
        op_sel      = '0;
        pick_onehot = '0;
        id_onehot   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_BITS'(i)) begin
                op_sel         = req_num[i*NUM_BITS +: NUM_BITS];
                pick_onehot[i] = 1'b1;
            end
            if (id_q == ID_BITS'(i)) begin
                id_onehot[i] = 1'b1;
            end
        end
        ack_hit = |(resp_ack & id_onehot);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        res_d       = res_q;
        req_rdy     = '0;
        resp_valid  = '0;
        resp_sqrt   = '0;
        resp_id     = '0;
        eng_trigger = 1'b0;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    if (clk_en) begin
                        req_rdy = pick_onehot;
                    end
                    op_d    = op_sel;
                    id_d    = pick_idx;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                eng_trigger = 1'b1;
                if (eng_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (eng_done) begin
                    res_d   = eng_sqrt;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = id_onehot;
                resp_sqrt  = res_q;
                resp_id    = id_q;
                if (ack_hit) begin
                    rr_ptr_d = (id_q == ID_BITS'(NUM_REQ - 1)) ? '0 : id_q + ID_BITS'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= '0;
            res_q    <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Randomized self-checking bench for sqrt_arbiter against a round-robin and
// floor-sqrt reference model.
module tb_sqrt_arbiter;

    localparam int NR = 4;
    localparam int NB = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_en;
    logic [NR-1:0]      req_valid;
    logic [NR*NB-1:0]   req_num;
    logic [NR-1:0]      req_rdy;
    logic [NR-1:0]      resp_valid;
    logic [NB-1:0]      resp_sqrt;
    logic [1:0]         resp_id;
    logic [NR-1:0]      resp_ack;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;

    sqrt_arbiter #(
        .NUM_REQ  (NR),
        .NUM_BITS (NB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_num    (req_num),
        .req_rdy    (req_rdy),
        .resp_valid (resp_valid),
        .resp_sqrt  (resp_sqrt),
        .resp_id    (resp_id),
        .resp_ack   (resp_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ref_sqrt(input longint unsigned x);
        longint unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return int'(r);
    endfunction

    function automatic int ref_winner(input logic [NR-1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int idx);
        logic [NR-1:0] v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: present mask/operands, wait for a response, ack ack_idx; returns observations.
    task automatic txn(input logic [NR-1:0] mask, input logic [NR*NB-1:0] ops, input int ack_idx,
                       output logic [NR-1:0] rdy_obs, output logic [NR-1:0] rv_obs,
                       output logic [1:0] id_obs, output logic [NB-1:0] sq_obs,
                       output int lat, output logic busy_after);
        req_num   = ops;
        req_valid = mask;
        #1;
        rdy_obs = req_rdy;
        tick();
        req_valid = '0;
        lat = 0;
        while (resp_valid == '0 && lat < 60) begin
            tick();
            lat++;
        end
        rv_obs = resp_valid;
        id_obs = resp_id;
        sq_obs = resp_sqrt;
        resp_ack = onehot(ack_idx);
        tick();
        resp_ack   = '0;
        busy_after = busy;
    endtask

    task automatic test_reset;
        reset = 1'b0; clk_en = 1'b1; req_valid = '0; req_num = '0; resp_ack = '0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        model_ptr = 0;
        n_checks++; if (req_rdy !== '0) begin n_fail++; $display("FAIL reset_req_rdy got=%b exp=0", req_rdy); end
        n_checks++; if (resp_valid !== '0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        n_checks++; if (resp_sqrt !== '0) begin n_fail++; $display("FAIL reset_resp_sqrt got=%0d exp=0", resp_sqrt); end
        n_checks++; if (resp_id !== '0) begin n_fail++; $display("FAIL reset_resp_id got=%0d exp=0", resp_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single;
        logic [NR-1:0] rdy, rv; logic [1:0] id; logic [NB-1:0] sq; int lat; logic b;
        logic [NR*NB-1:0] ops = '0;
        int w;
        ops[2*NB +: NB] = 16'd144;
        w = ref_winner(4'b0100, model_ptr);
        txn(4'b0100, ops, w, rdy, rv, id, sq, lat, b);
        n_checks++; if (rdy !== onehot(w)) begin n_fail++; $display("FAIL single_rdy got=%b exp=%b", rdy, onehot(w)); end
        n_checks++; if (rv !== onehot(w)) begin n_fail++; $display("FAIL single_resp_valid got=%b exp=%b", rv, onehot(w)); end
        n_checks++; if (int'(id) !== w) begin n_fail++; $display("FAIL single_resp_id got=%0d exp=%0d", id, w); end
        n_checks++; if (int'(sq) !== ref_sqrt(144)) begin n_fail++; $display("FAIL single_sqrt got=%0d exp=%0d", sq, ref_sqrt(144)); end
        n_checks++; if (lat < 3 || lat > NB + 3) begin n_fail++; $display("FAIL single_latency got=%0d exp=3..%0d", lat, NB + 3); end
        n_checks++; if (b !== 1'b0) begin n_fail++; $display("FAIL single_idle_after_ack got=%b exp=0", b); end
        model_ptr = (w + 1) % NR;
        req_valid = '1;
        #1;
        n_checks++; if (req_rdy !== onehot(ref_winner('1, model_ptr))) begin
            n_fail++; $display("FAIL single_rr_ptr got=%b exp=%b", req_rdy, onehot(ref_winner('1, model_ptr)));
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_edge_operands;
        int unsigned vals[6] = '{0, 1, 65535, 65024, 255, 256};
        logic [NR-1:0] rdy, rv; logic [1:0] id; logic [NB-1:0] sq; int lat; logic b;
        for (int k = 0; k < 6; k++) begin
            int r = int'($urandom_range(0, NR - 1));
            logic [NR*NB-1:0] ops = {$urandom, $urandom};
            logic [NR-1:0] mask = onehot(r);
            int w = ref_winner(mask, model_ptr);
            ops[r*NB +: NB] = NB'(vals[k]);
            txn(mask, ops, w, rdy, rv, id, sq, lat, b);
            n_checks++; if (rdy !== onehot(w) || rv !== onehot(w) || int'(id) !== w) begin
                n_fail++; $display("FAIL edge_route op=%0d rdy=%b rv=%b id=%0d exp_id=%0d", vals[k], rdy, rv, id, w);
            end
            n_checks++; if (int'(sq) !== ref_sqrt(longint'(vals[k]))) begin
                n_fail++; $display("FAIL edge_sqrt op=%0d got=%0d exp=%0d", vals[k], sq, ref_sqrt(longint'(vals[k])));
            end
            model_ptr = (w + 1) % NR;
        end
    endtask

    task automatic test_random;
        logic [NR-1:0] rdy, rv; logic [1:0] id; logic [NB-1:0] sq; int lat; logic b;
        for (int k = 0; k < 12; k++) begin
            logic [NR-1:0] mask = NR'($urandom_range(1, (1 << NR) - 1));
            logic [NR*NB-1:0] ops = {$urandom, $urandom};
            int w = ref_winner(mask, model_ptr);
            int exp_sq = ref_sqrt(longint'(ops[w*NB +: NB]));
            txn(mask, ops, w, rdy, rv, id, sq, lat, b);
            n_checks++; if (rdy !== onehot(w) || rv !== onehot(w) || int'(id) !== w) begin
                n_fail++; $display("FAIL random_route mask=%b rdy=%b rv=%b id=%0d exp_id=%0d", mask, rdy, rv, id, w);
            end
            n_checks++; if (int'(sq) !== exp_sq || lat > NB + 3 || b !== 1'b0) begin
                n_fail++; $display("FAIL random_result got=%0d exp=%0d lat=%0d busy_after=%b", sq, exp_sq, lat, b);
            end
            model_ptr = (w + 1) % NR;
        end
    endtask

    task automatic test_back_to_back;
        logic [NR*NB-1:0] ops;
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        reset = 1'b0; tick(); reset = 1'b1;
        model_ptr = 0;
        ops = {16'd25, 16'd16, 16'd9, 16'd4};
        req_num = ops;
        req_valid = '1;
        for (int t = 0; t < 5; t++) begin
            int w = ref_winner('1, model_ptr);
            int waited = 0;
            logic leak = 1'b0;
            #1;
            while (req_rdy == '0 && waited < 6) begin tick(); waited++; end
            n_checks++; if (req_rdy !== onehot(w) || (t > 0 && waited != 0)) begin
                n_fail++; $display("FAIL b2b_grant t=%0d got=%b exp=%b waited=%0d", t, req_rdy, onehot(w), waited);
            end
            order.push_back(req_rdy == onehot(w) ? w : -1);
            tick();
            waited = 0;
            while (resp_valid == '0 && waited < 60) begin
                if (req_rdy != '0) leak = 1'b1;
                tick(); waited++;
            end
            if (req_rdy != '0) leak = 1'b1;
            n_checks++; if (leak !== 1'b0 || int'(resp_id) !== w || int'(resp_sqrt) !== ref_sqrt(longint'(ops[w*NB +: NB]))) begin
                n_fail++; $display("FAIL b2b_result t=%0d id=%0d exp_id=%0d sqrt=%0d exp=%0d rdy_leak=%b",
                                   t, resp_id, w, resp_sqrt, ref_sqrt(longint'(ops[w*NB +: NB])), leak);
            end
            resp_ack = onehot(w);
            tick();
            resp_ack = '0;
            model_ptr = (w + 1) % NR;
        end
        req_valid = '0;
        for (int t = 0; t < 5; t++) begin
            n_checks++; if (order[t] !== exp_order[t]) begin
                n_fail++; $display("FAIL b2b_order t=%0d got=%0d exp=%0d", t, order[t], exp_order[t]);
            end
        end
    endtask

    task automatic test_delayed_ack;
        logic [NR*NB-1:0] ops = {$urandom, $urandom};
        int exp_sq = ref_sqrt(longint'(ops[NB-1:0]));
        int waited = 0;
        logic bad = 1'b0;
        req_num = ops;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        while (resp_valid == '0 && waited < 60) begin tick(); waited++; end
        for (int c = 0; c < 10; c++) begin
            resp_ack = (c % 3 == 1) ? 4'b0010 : 4'b0000;
            tick();
            resp_ack = '0;
            if (resp_valid !== 4'b0001 || resp_id !== 2'd0 || int'(resp_sqrt) !== exp_sq || busy !== 1'b1) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) begin
            n_fail++; $display("FAIL delayed_hold rv=%b id=%0d sqrt=%0d exp_sqrt=%0d", resp_valid, resp_id, resp_sqrt, exp_sq);
        end
        resp_ack = 4'b0001;
        tick();
        resp_ack = '0;
        n_checks++; if (resp_valid !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL delayed_complete rv=%b busy=%b exp=0/0", resp_valid, busy);
        end
        model_ptr = 1;
    endtask

    task automatic test_clk_en;
        int r = int'($urandom_range(0, NR - 1));
        logic [NR*NB-1:0] ops = {$urandom, $urandom};
        int hs = 0;
        logic rdy_bad = 1'b0, seen = 1'b0, fin = 1'b0, hs_now;
        logic [NB-1:0] sq = '0;
        ops[r*NB +: NB] = 16'd50000;
        req_num = ops;
        req_valid = onehot(r);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            clk_en = (cyc % 2 == 0);
            #1;
            hs_now = |(req_valid & req_rdy);
            if (!clk_en && req_rdy != '0) rdy_bad = 1'b1;
            if (hs_now) hs++;
            if (resp_valid != '0 && !seen) begin
                seen = 1'b1;
                sq = resp_sqrt;
                resp_ack = onehot(r);
            end
            if (seen && resp_valid == '0) begin
                fin = 1'b1;
            end else begin
                tick();
                if (hs_now) req_valid = '0;
            end
        end
        resp_ack = '0;
        clk_en = 1'b1;
        req_valid = '0;
        #1;
        n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL clken_handshakes got=%0d exp=1", hs); end
        n_checks++; if (rdy_bad !== 1'b0) begin n_fail++; $display("FAIL clken_rdy_gated got=%b exp=0", rdy_bad); end
        n_checks++; if (int'(sq) !== ref_sqrt(50000) || !fin) begin
            n_fail++; $display("FAIL clken_sqrt got=%0d exp=%0d completed=%b", sq, ref_sqrt(50000), fin);
        end
        model_ptr = (r + 1) % NR;
    endtask

    task automatic test_reset_mid;
        logic [NR-1:0] rdy, rv; logic [1:0] id; logic [NB-1:0] sq; int lat; logic b;
        logic [NR*NB-1:0] ops = '0;
        logic stray = 1'b0;
        int w;
        ops[2*NB +: NB] = 16'd400;
        txn(4'b0100, ops, 2, rdy, rv, id, sq, lat, b);
        model_ptr = 3;
        ops[3*NB +: NB] = 16'd900;
        req_num = ops;
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before got=%b exp=1", busy); end
        reset = 1'b0;
        tick();
        n_checks++; if (req_rdy !== '0 || resp_valid !== '0 || resp_sqrt !== '0 || resp_id !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs rdy=%b rv=%b sqrt=%0d id=%0d busy=%b exp=all 0",
                               req_rdy, resp_valid, resp_sqrt, resp_id, busy);
        end
        reset = 1'b1;
        model_ptr = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (resp_valid != '0 || busy) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL midreset_no_response got=%b exp=0", stray); end
        ops = {$urandom, $urandom};
        w = ref_winner(4'b1010, model_ptr);
        txn(4'b1010, ops, w, rdy, rv, id, sq, lat, b);
        n_checks++; if (rdy !== onehot(w) || int'(id) !== w || int'(sq) !== ref_sqrt(longint'(ops[w*NB +: NB]))) begin
            n_fail++; $display("FAIL midreset_replay rdy=%b id=%0d exp_id=%0d sqrt=%0d exp=%0d",
                               rdy, id, w, sq, ref_sqrt(longint'(ops[w*NB +: NB])));
        end
        model_ptr = (w + 1) % NR;
    endtask

    initial begin
        test_reset();
        test_single();
        test_edge_operands();
        test_random();
        test_back_to_back();
        test_delayed_ack();
        test_clk_en();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Round-robin arbiter that shares one integer-square-root engine (`IntSqrt`) among `NUM_REQ` requesters in the plotter datapath, such as segment-length and arc-radius stages. It accepts one request at a time and sequences the engine through trigger and completion. It then returns the result to the winning requester and holds it there until that requester acknowledges.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2, power of two not required.
- `NUM_BITS`, 16: operand/result width, passed to the engine.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-low reset.
- `clk_en`  in  1: module enable. When low, all state freezes and all outputs hold, except `req_rdy`, which is forced to 0.
- `req_valid`  in  NUM_REQ: per-requester request strobe. Held until accepted.
- `req_num`  in  NUM_REQ*NUM_BITS: packed operands. Requester i uses bits [i*NUM_BITS +: NUM_BITS].
- `req_rdy`  out  NUM_REQ: one-hot acceptance, combinational from state and `req_valid`.
- `resp_valid`  out  NUM_REQ: one-hot result-valid, held until acknowledged.
- `resp_sqrt`  out  NUM_BITS: floor(sqrt(operand)), shared by all requesters.
- `resp_id`  out  $clog2(NUM_REQ): index of the requester being answered.
- `resp_ack`  in  NUM_REQ: per-requester acknowledge.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE → LAUNCH → WAIT → RESP → IDLE. State advances only on cycles with `clk_en`=1.
- **IDLE**
  - If any `req_valid` is high, winner = first index at or after `rr_ptr`, scanning upward and wrapping at NUM_REQ.
  - `req_rdy[winner]`=1 this cycle. The handshake is `req_valid & req_rdy`.
  - On that edge: latch operand into `op_reg`, winner into `id_reg`, go to LAUNCH.
- **LAUNCH**
  - Drive engine `num_in`=`op_reg` and `trigger`=1.
  - On the edge where engine `rdy`=1, go to WAIT. Otherwise stay.
- **WAIT**
  - `trigger`=0.
  - On the first cycle with engine `done`=1, latch `sqrt_out` into `res_reg` and go to RESP.
  - The engine deasserts `done` on trigger acceptance, so a stale `done` is never sampled.
- **RESP**
  - `resp_valid[id_reg]`=1, `resp_id`=`id_reg`, `resp_sqrt`=`res_reg`.
  - On `resp_ack[id_reg]`=1: set `rr_ptr` ← (`id_reg`+1) mod NUM_REQ and go to IDLE.
  - Acks on other indices are ignored.
- Reset values: state IDLE, `rr_ptr`=0, `op_reg`/`res_reg`/`id_reg`=0. All outputs 0: `req_rdy`, `resp_valid`, `resp_sqrt`, `resp_id`, `busy`.
- The engine's active-high `reset` is driven by the inverted `reset`. The arbiter's reset therefore also reinitialises the engine.
- Reset mid-operation (any state): the in-flight request and its result are discarded, with no response. The requester must re-present its request.
- If a requester drops `req_valid` before acceptance, no effect. `req_valid` on the requester currently being served, outside IDLE, is ignored until the next IDLE.
- Operand 0 → result 0. Operand 2^NUM_BITS−1 → 2^(NUM_BITS/2)−1 for even NUM_BITS.

## Timing
- Accept at edge T (IDLE).
- Trigger asserted during cycle T+1. Engine accepts at T+1 when idle.
- Result in RESP by T+2+L, where L is engine iterations (≤ NUM_BITS+1).
- `resp_valid` is visible during the cycle after the WAIT edge on which `done` is seen.
- Ack in the first RESP cycle is valid. With back-to-back requests, the next `req_rdy` can assert in the cycle right after the ack edge. Minimum spacing is 4 cycles plus L.
- At most one request is outstanding. `req_rdy` is never high outside IDLE.
- Fairness: under continuous contention from all requesters, each is served once every NUM_REQ transactions.
- `clk_en` low in any state stretches that state by exactly the number of low cycles. There is no loss or duplication of handshakes.

## Structure
- Shared package `sqrt_arbiter_pkg`:
  - `sqrt_arb_state_t` enum (IDLE, LAUNCH, WAIT, RESP).
  - Localparam `SQRT_ARB_ID_BITS` function of NUM_REQ.
- One sub-module: `rr_pick`, combinational round-robin first-set-at-or-after-pointer selector, returning index and a found flag.
- Engine instance: existing `IntSqrt`, with `NUM_BITS` passed through.
- Everything else (FSM, registers, output muxing) lives in the top module.

## Test plan
- Single request: requester 2, operand 144 → accepted in IDLE. `resp_valid[2]`, `resp_id`=2, `resp_sqrt`=12, held until `resp_ack[2]`, then IDLE and `rr_ptr`=3.
- Edge operands: 0 → 0; 1 → 1; 65535 → 255; 65024 → 254 (floor check).
- All four requesting continuously with operands 4, 9, 16, 25: service order 0,1,2,3,0, results 2,3,4,5. Exactly one `req_rdy` high per IDLE.
- Delayed ack: ack withheld 10 cycles, and `resp_ack[1]` is pulsed while serving id 0 → outputs stable, wrong ack ignored. Completion only on `resp_ack[0]`.
- `clk_en` toggling 1/0 every cycle during operand 50000 → result 223. Handshake counts match, and `req_rdy`=0 in all `clk_en`=0 cycles.
- `reset`=0 asserted for one cycle while in WAIT → next cycle all outputs 0, state IDLE, `rr_ptr`=0. No response for the discarded request, and a re-presented request is served correctly.
